// File: rtl/adder_char_pkg.sv
// ---------------------------------------------------------------------------
// adder_char_pkg
//   Shared types and width helpers for the approximate-adder error sweep.
//   - state_e      : sweep controller states
//   - DRAIN_CYCLES : cycles needed to flush the statistics pipeline
//   - sse_w/bias_w/cnt_w : accumulator widths derived from the operand width
// ---------------------------------------------------------------------------
package adder_char_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The last pair still has to travel through S1 and S2 after it is sampled.
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Widths sized so that no accumulator can overflow over a full sweep for
  // any AUT output: 2^(2w) pairs, |err| < 2^(w+1).
  function automatic int sse_w(input int w);
    return 4 * w + 2;
  endfunction

  function automatic int bias_w(input int w);
    return 3 * w + 2;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/adder_err_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// adder_err_sweep_ctrl_if
//   Control, AUT and statistics bundle of the adder error sweep.
//   master : host/testbench side (drives start/abort/pause and the AUT result)
//   slave  : sweep controller side (drives operands, status and statistics)
// ---------------------------------------------------------------------------
interface adder_err_sweep_ctrl_if
  import adder_char_pkg::*;
#(
  parameter int W      = 8,
  parameter int SSE_W  = sse_w(W),
  parameter int BIAS_W = bias_w(W),
  parameter int CNT_W  = cnt_w(W)
);

  logic                     start;
  logic                     abort;
  logic                     pause;
  logic [W-1:0]             op_a;
  logic [W-1:0]             op_b;
  logic [W:0]               aut_sum;
  logic                     busy;
  logic                     done;
  logic [SSE_W-1:0]         sse;
  logic signed [BIAS_W-1:0] bias;
  logic [W:0]               max_abs_err;
  logic [CNT_W-1:0]         err_cnt;

  modport master (
    output start, abort, pause, aut_sum,
    input  op_a, op_b, busy, done, sse, bias, max_abs_err, err_cnt
  );

  modport slave (
    input  start, abort, pause, aut_sum,
    output op_a, op_b, busy, done, sse, bias, max_abs_err, err_cnt
  );

endinterface

// File: rtl/adder_err_sweep_ctrl_err_stat_pipe.sv
// ---------------------------------------------------------------------------
// err_stat_pipe
//   Three-stage error statistics pipeline, one operand pair per cycle.
//   S0: err = aut_sum - (op_a + op_b), signed W+2 bits
//   S1: err, err^2, |err|, err != 0
//   S2: accumulate sse, bias, err_cnt and track max |err|
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous clear of valids and statistics
//   sample       capture the current pair into S0 this cycle
//   op_a, op_b   operands currently presented to the AUT
//   aut_sum      AUT result for op_a/op_b
//   sse, bias, max_abs_err, err_cnt   registered statistics
// ---------------------------------------------------------------------------
module err_stat_pipe
  import adder_char_pkg::*;
#(
  parameter int W      = 8,
  parameter int SSE_W  = sse_w(W),
  parameter int BIAS_W = bias_w(W),
  parameter int CNT_W  = cnt_w(W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     sample,
  input  logic [W-1:0]             op_a,
  input  logic [W-1:0]             op_b,
  input  logic [W:0]               aut_sum,
  output logic [SSE_W-1:0]         sse,
  output logic signed [BIAS_W-1:0] bias,
  output logic [W:0]               max_abs_err,
  output logic [CNT_W-1:0]         err_cnt
);

  // Square of a (W+2)-bit signed value needs 2W+3 bits; one spare keeps it
  // representable as a signed product before reinterpreting as unsigned.
  localparam int SQ_W = 2 * W + 4;

  logic [W:0]               exact_sum;
  logic signed [W+1:0]      err_s0;
  logic signed [SQ_W-1:0]   err_wide;
  logic [W:0]               abs_s1;

  logic                     valid0_q, valid0_d;
  logic signed [W+1:0]      err0_q,   err0_d;
  logic                     valid1_q, valid1_d;
  logic signed [W+1:0]      err1_q,   err1_d;
  logic [SQ_W-1:0]          sq1_q,    sq1_d;
  logic [W:0]               abs1_q,   abs1_d;
  logic                     nz1_q,    nz1_d;
  logic [SSE_W-1:0]         sse_q,    sse_d;
  logic signed [BIAS_W-1:0] bias_q,   bias_d;
  logic [W:0]               max_q,    max_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;

  // Both operands are zero-extended by one bit so the difference spans the
  // full range -(2^(W+1)-2) .. 2^(W+1)-1 without wrap.
  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
  assign err_s0    = $signed({1'b0, aut_sum}) - $signed({1'b0, exact_sum});
  assign err_wide  = SQ_W'(err0_q);
  assign abs_s1    = (W + 1)'(err0_q[W+1] ? -err0_q : err0_q);

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    valid0_d = valid0_q;
    err0_d   = err0_q;
    valid1_d = valid1_q;
    err1_d   = err1_q;
    sq1_d    = sq1_q;
    abs1_d   = abs1_q;
    nz1_d    = nz1_q;
    sse_d    = sse_q;
    bias_d   = bias_q;
    max_d    = max_q;
    cnt_d    = cnt_q;

    if (clear) begin
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      sse_d    = '0;
      bias_d   = '0;
      max_d    = '0;
      cnt_d    = '0;
    end else begin
      // S0: a cycle without sample is a bubble.
      valid0_d = sample;
      if (sample) begin
        err0_d = err_s0;
      end

      // S1
      valid1_d = valid0_q;
      if (valid0_q) begin
        err1_d = err0_q;
        sq1_d  = $unsigned(err_wide * err_wide);
        abs1_d = abs_s1;
        nz1_d  = (err0_q != '0);
      end

      // S2
      if (valid1_q) begin
        sse_d  = sse_q + SSE_W'(sq1_q);
        bias_d = bias_q + BIAS_W'(err1_q);
        cnt_d  = cnt_q + CNT_W'(nz1_q);
        if (abs1_q > max_q) begin
          max_d = abs1_q;
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every stage sees the previous cycle's values of the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      err0_q   <= '0;
      valid1_q <= 1'b0;
      err1_q   <= '0;
      sq1_q    <= '0;
      abs1_q   <= '0;
      nz1_q    <= 1'b0;
      sse_q    <= '0;
      bias_q   <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      err0_q   <= err0_d;
      valid1_q <= valid1_d;
      err1_q   <= err1_d;
      sq1_q    <= sq1_d;
      abs1_q   <= abs1_d;
      nz1_q    <= nz1_d;
      sse_q    <= sse_d;
      bias_q   <= bias_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sse         = sse_q;
  assign bias        = bias_q;
  assign max_abs_err = max_q;
  assign err_cnt     = cnt_q;

endmodule

// File: rtl/adder_err_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// adder_err_sweep_ctrl
//   Sweeps an approximate W-bit adder through every (a, b) pair (b inner,
//   a outer) and accumulates error statistics against the exact sum.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus (slave) start/abort/pause in, aut_sum in; op_a/op_b, busy, done,
//               sse, bias, max_abs_err, err_cnt out (all registered)
// ---------------------------------------------------------------------------
module adder_err_sweep_ctrl
  import adder_char_pkg::*;
#(
  parameter int W      = 8,
  parameter int SSE_W  = sse_w(W),
  parameter int BIAS_W = bias_w(W),
  parameter int CNT_W  = cnt_w(W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_err_sweep_ctrl_if.slave bus
);

  localparam logic [W-1:0]           OP_MAX    = '1;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_END = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [W-1:0]            op_a_q,  op_a_d;
  logic [W-1:0]            op_b_q,  op_b_d;
  logic [DRAIN_CNT_W-1:0]  drain_q, drain_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic                    sample;
  logic                    clear;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    sample  = 1'b0;
    clear   = 1'b0;

    if (bus.abort) begin
      // Abort wins over start and is honoured in every state.
      state_d = IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
      drain_d = '0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = RUN;
            op_a_d  = '0;
            op_b_d  = '0;
            clear   = 1'b1;
          end
        end
        RUN: begin
          if (!bus.pause) begin
            sample = 1'b1;
            if (op_a_q == OP_MAX && op_b_q == OP_MAX) begin
              // Final pair: operands stay at (max, max) until the next start.
              state_d = DRAIN;
              drain_d = '0;
            end else begin
              op_b_d = op_b_q + W'(1);
              if (op_b_q == OP_MAX) begin
                op_a_d = op_a_q + W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_END) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + DRAIN_CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.op_a = op_a_q;
  assign bus.op_b = op_b_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // The pair currently on op_a/op_b is sampled on the same edge that
  // advances the operands.
  err_stat_pipe #(
    .W      (W),
    .SSE_W  (SSE_W),
    .BIAS_W (BIAS_W),
    .CNT_W  (CNT_W)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample      (sample),
    .op_a        (op_a_q),
    .op_b        (op_b_q),
    .aut_sum     (bus.aut_sum),
    .sse         (bus.sse),
    .bias        (bus.bias),
    .max_abs_err (bus.max_abs_err),
    .err_cnt     (bus.err_cnt)
  );

endmodule

// File: tb/tb_adder_err_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_err_sweep_ctrl
//   Directed bench with two instances: a full W=8 sweep against a constant-0
//   AUT, and a W=4 instance (256 pairs) for exact, +1, pause, restart-while-
//   busy, abort and mid-run reset scenarios. Expected values are hand-derived:
//   for a constant-0 AUT with N = 2^W, sse = 2*N*sum(a^2) + 2*(sum a)^2 and
//   bias = -2*N*sum(a).
// ---------------------------------------------------------------------------
module tb_adder_err_sweep_ctrl;

  localparam int AUT_EXACT = 0;
  localparam int AUT_ZERO  = 1;
  localparam int AUT_PLUS1 = 2;

  logic clk;
  logic rst_n;
  int   mode8;
  int   mode4;
  int   n_checks;
  int   n_pass;

  adder_err_sweep_ctrl_if #(.W(8)) b8 ();
  adder_err_sweep_ctrl_if #(.W(4)) b4 ();

  adder_err_sweep_ctrl #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  adder_err_sweep_ctrl #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural AUT models (combinational).
  always_comb begin
    case (mode8)
      AUT_ZERO:  b8.aut_sum = '0;
      AUT_PLUS1: b8.aut_sum = {1'b0, b8.op_a} + {1'b0, b8.op_b} + 9'd1;
      default:   b8.aut_sum = {1'b0, b8.op_a} + {1'b0, b8.op_b};
    endcase
    case (mode4)
      AUT_ZERO:  b4.aut_sum = '0;
      AUT_PLUS1: b4.aut_sum = {1'b0, b4.op_a} + {1'b0, b4.op_b} + 5'd1;
      default:   b4.aut_sum = {1'b0, b4.op_a} + {1'b0, b4.op_b};
    endcase
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_stats4(input string tag, input longint sse, input longint bias,
                              input longint mx, input longint cnt);
    check({tag, "_sse"},  longint'(b4.sse), sse);
    check({tag, "_bias"}, longint'($signed(b4.bias)), bias);
    check({tag, "_max"},  longint'(b4.max_abs_err), mx);
    check({tag, "_cnt"},  longint'(b4.err_cnt), cnt);
  endtask

  // Runs one W=4 sweep. cyc counts clock edges after the start edge, so done
  // is expected at cyc = 256 + 2 (+ pause length). Negative arguments disable
  // the pause / restart injections.
  task automatic run4(input int pause_at, input int pause_len, input int restart_at,
                      output int cyc);
    int idx;
    @(negedge clk) b4.start = 1'b1;
    @(negedge clk) b4.start = 1'b0;
    cyc = 0;
    while (!b4.done && cyc < 2000) begin
      if (pause_at >= 0 && cyc == pause_at) b4.pause = 1'b1;
      if (pause_at >= 0 && cyc == pause_at + pause_len) begin
        b4.pause = 1'b0;
        check("pause_op_a", longint'(b4.op_a), longint'(pause_at / 16));
        check("pause_op_b", longint'(b4.op_b), longint'(pause_at % 16));
      end
      if (restart_at >= 0 && cyc == restart_at)     b4.start = 1'b1;
      if (restart_at >= 0 && cyc == restart_at + 1) b4.start = 1'b0;
      if (restart_at >= 0 && cyc == restart_at + 20) begin
        idx = restart_at + 20;
        check("restart_op_a", longint'(b4.op_a), longint'(idx / 16));
        check("restart_op_b", longint'(b4.op_b), longint'(idx % 16));
        check("restart_busy", longint'(b4.busy), 1);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  int  cyc;
  bit  saw_done;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mode8    = AUT_ZERO;
    mode4    = AUT_EXACT;
    b8.start = 1'b0; b8.abort = 1'b0; b8.pause = 1'b0;
    b4.start = 1'b0; b4.abort = 1'b0; b4.pause = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",  longint'(b8.busy), 0);
    check("rst_done",  longint'(b8.done), 0);
    check("rst_op_a",  longint'(b8.op_a), 0);
    check("rst_sse",   longint'(b8.sse), 0);
    check_stats4("rst4", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full W=8 sweep, constant-0 AUT
    b8.start = 1'b1;
    @(negedge clk) b8.start = 1'b0;
    cyc = 0;
    while (!b8.done && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_cycles", cyc, 65538);
    check("w8_done",   longint'(b8.done), 1);
    check("w8_sse",    longint'(b8.sse), 64'd4977295360);
    check("w8_bias",   longint'($signed(b8.bias)), -64'sd16711680);
    check("w8_max",    longint'(b8.max_abs_err), 510);
    check("w8_cnt",    longint'(b8.err_cnt), 65535);
    @(negedge clk);
    check("w8_done_pulse", longint'(b8.done), 0);
    check("w8_busy_after", longint'(b8.busy), 0);

    // W=4 exact AUT
    mode4 = AUT_EXACT;
    run4(-1, 0, -1, cyc);
    check("exact_cycles", cyc, 258);
    check_stats4("exact", 0, 0, 0, 0);
    @(negedge clk);
    check("exact_done_pulse", longint'(b4.done), 0);
    check("exact_hold_a", longint'(b4.op_a), 15);
    check("exact_hold_b", longint'(b4.op_b), 15);

    // W=4 exact AUT with 100-cycle pause after 50 pairs
    run4(50, 100, -1, cyc);
    check("pause_cycles", cyc, 358);
    check_stats4("pause", 0, 0, 0, 0);

    // W=4 +1 AUT with a start pulse while running (ignored)
    mode4 = AUT_PLUS1;
    run4(-1, 0, 20, cyc);
    check("plus1_cycles", cyc, 258);
    check_stats4("plus1", 256, 256, 1, 256);

    // W=4 constant-0 AUT, abort after 100 edges
    mode4 = AUT_ZERO;
    @(negedge clk) b4.start = 1'b1;
    @(negedge clk) b4.start = 1'b0;
    repeat (100) @(negedge clk);
    // Pairs 0..97 have reached S2; only pair (0,0) is error-free.
    check("pre_abort_cnt", longint'(b4.err_cnt), 97);
    b4.abort = 1'b1;
    @(negedge clk) b4.abort = 1'b0;
    check("abort_busy", longint'(b4.busy), 0);
    check("abort_op_a", longint'(b4.op_a), 0);
    check("abort_op_b", longint'(b4.op_b), 0);
    check_stats4("abort", 0, 0, 0, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b4.done) saw_done = 1'b1;
    end
    check("abort_no_done", longint'(saw_done), 0);
    check_stats4("abort_hold", 0, 0, 0, 0);
    run4(-1, 0, -1, cyc);
    check("zero_cycles", cyc, 258);
    check_stats4("zero", 68480, -3840, 30, 255);

    // W=4 +1 AUT, async reset mid-run
    mode4 = AUT_PLUS1;
    @(negedge clk) b4.start = 1'b1;
    @(negedge clk) b4.start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_cnt", longint'(b4.err_cnt), 28);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", longint'(b4.busy), 0);
    check("midrst_op_a", longint'(b4.op_a), 0);
    check("midrst_op_b", longint'(b4.op_b), 0);
    check_stats4("midrst", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", longint'(b4.busy), 0);
    check("post_rst_cnt", longint'(b4.err_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_err_sweep_ctrl.md
Name: adder_err_sweep_ctrl

Overview:
- Sequencer that drives an approximate W-bit adder-under-test (AUT) through every operand pair (a, b), a and b each 0..2^W-1.
- Compares each AUT sum against an internal exact sum and accumulates error statistics: sum of squared error, signed error sum, maximum absolute error and erroneous-pair count.
- Sits beside any combinational approximate adder in the adder library, which is wired to op_a/op_b/aut_sum.
- Provides on-chip MSE and bias characterisation of that adder.

Parameters:
- W, 8: operand width; AUT sum width is W+1.
- SSE_W, 4*W+2: squared-error accumulator width (34 bits at W=8).
- BIAS_W, 3*W+2: signed error-sum width (26 bits at W=8).
- CNT_W, 2*W+1: error-count width (17 bits at W=8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sweep; ignored unless in IDLE or DONE.
- abort  in  1  stops a sweep; returns to IDLE and clears statistics.
- pause  in  1  while high in RUN, operands hold and no pair is consumed.
- op_a  out  W  operand A to the AUT.
- op_b  out  W  operand B to the AUT.
- aut_sum  in  W+1  combinational AUT result for the current op_a/op_b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- sse  out  SSE_W  sum over all pairs of (aut_sum - (a+b))^2.
- bias  out  BIAS_W  signed sum of (aut_sum - (a+b)).
- max_abs_err  out  W+1  largest |aut_sum - (a+b)|.
- err_cnt  out  CNT_W  number of pairs with a nonzero error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; op_a, op_b, sse, bias, max_abs_err, err_cnt all 0; busy=0; done=0. Pipeline valid flags are cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE, start=1 -> RUN. Clears all statistics and sets op_a=op_b=0.
  - RUN -> DRAIN after the cycle in which the pair (2^W-1, 2^W-1) is consumed.
  - DRAIN lasts exactly 2 cycles, then -> DONE with done=1 for one cycle.
  - DONE holds statistics until the next start.
- Operand order: op_b is the inner index. On each consumed cycle op_b increments; when op_b wraps from 2^W-1 to 0, op_a increments. The final pair does not advance the operands; they hold at (max, max) until the next start.
- Pipeline (3 stages, fully pipelined, one pair per cycle when pause=0):
  - S0: on each RUN clock edge with pause=0, register err = aut_sum - (op_a+op_b) as (W+2)-bit signed, and set valid0.
  - S1: register err, err*err, |err|, and (err!=0); propagate valid.
  - S2: when valid, sse += sq, bias += err (sign-extended), err_cnt += nz, max_abs_err = max(max_abs_err, |err|).
  - Statistics are final 2 cycles after the last pair is sampled, which is why DRAIN is 2 cycles. Total start-to-done = 2^(2W) + 2 cycles plus pause cycles.
- Pause: sampled every RUN cycle. When high, the S0 valid bit is 0 (bubble) and operands hold. Pause is ignored outside RUN; in DRAIN the pipeline still flushes.
- Abort (any state, synchronous): -> IDLE; statistics and operands cleared; pipeline valids cleared. Abort has priority over start in the same cycle.
- start while busy: ignored.
- Arithmetic: all accumulators wrap modulo their width. Default widths are sized so no overflow occurs for any AUT output at W=8.
- Outputs are registered only; no combinational path from any input to any output.

Decomposition:
- Shared package adder_char_pkg: state enum {IDLE, RUN, DRAIN, DONE}, DRAIN_CYCLES=2, width-derivation functions for SSE_W/BIAS_W/CNT_W.
- One sub-module, err_stat_pipe: stages S0-S2 and the accumulators. The controller keeps the FSM and operand counters.

Test Plan:
- Exact adder as AUT, start -> done after 65538 cycles; sse=0, bias=0, max_abs_err=0, err_cnt=0.
- AUT outputs constant 0 -> sse=4977295360, bias=-16711680, max_abs_err=510, err_cnt=65535.
- AUT outputs a+b+1 -> sse=65536, bias=65536, max_abs_err=1, err_cnt=65536.
- Exact AUT with pause high for 100 cycles mid-run -> done at cycle 65638; statistics identical to the exact case; operands frozen during pause.
- Constant-0 AUT, abort at cycle 1000 -> IDLE next cycle, all statistics 0, busy=0, no done pulse. A following start gives the full constant-0 results.
- rst_n pulsed low mid-run -> all outputs 0 immediately (async). start pulse during RUN -> no restart; counters continue.
